// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// An accepted op is latched, evaluated during the following EXEC cycle and
// written into that requester's response register, which holds until popped.

// Shared combinational ALU. Undefined control codes yield result 0, zero 1, branch 0.
module alu_arbiter_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [5:0]            i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_zero,
    output logic                  o_branch
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] w_shamt;
    logic           w_eq;
    logic           w_lt_s;
    logic           w_lt_u;

    assign w_shamt = i_op_b[SHW-1:0];
    assign w_eq    = (i_op_a == i_op_b);
    assign w_lt_s  = ($signed(i_op_a) < $signed(i_op_b));
    assign w_lt_u  = (i_op_a < i_op_b);

    // Decode the control code; branch codes (ctrl[4:3]==2'b10) return the condition as result.
    always_comb begin
        o_result = {DATA_WIDTH{1'b0}};
        o_branch = 1'b0;
        case (i_ctrl)
            6'b000000: o_result = i_op_a + i_op_b;
            6'b001000: o_result = i_op_a - i_op_b;
            6'b000001: o_result = i_op_a << w_shamt;
            6'b000010: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
            6'b000011: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
            6'b000100: o_result = i_op_a ^ i_op_b;
            6'b000101: o_result = i_op_a >> w_shamt;
            6'b001101: o_result = $unsigned($signed(i_op_a) >>> w_shamt);
            6'b000110: o_result = i_op_a | i_op_b;
            6'b000111: o_result = i_op_a & i_op_b;
            6'b010000: o_branch = w_eq;
            6'b010001: o_branch = ~w_eq;
            6'b010100: o_branch = w_lt_s;
            6'b010101: o_branch = ~w_lt_s;
            6'b010110: o_branch = w_lt_u;
            6'b010111: o_branch = ~w_lt_u;
            default:   o_branch = 1'b0;
        endcase
        if (i_ctrl[5:3] == 3'b010) begin
            o_result = {{(DATA_WIDTH-1){1'b0}}, o_branch};
        end else begin
            o_result = o_result;
        end
        o_zero = (o_result == {DATA_WIDTH{1'b0}});
    end
endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [11:0]             req_ctrl,
    input  logic [2*DATA_WIDTH-1:0] req_op_a,
    input  logic [2*DATA_WIDTH-1:0] req_op_b,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_result,
    output logic [1:0]              rsp_zero,
    output logic [1:0]              rsp_branch,
    output logic                    busy
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_prio;
    logic                    r_owner;
    logic [5:0]              r_ctrl;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic [1:0]              r_rsp_valid;
    logic [2*DATA_WIDTH-1:0] r_rsp_result;
    logic [1:0]              r_rsp_zero;
    logic [1:0]              r_rsp_branch;

    logic [1:0]              w_eligible;
    logic [1:0]              w_grant;
    logic [5:0]              w_sel_ctrl;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic                    w_alu_zero;
    logic                    w_alu_branch;

    // A requester whose response slot is still full cannot be granted.
    assign w_eligible = req_valid & ~r_rsp_valid;

    alu_arbiter_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_ctrl   (r_ctrl),
        .i_op_a   (r_op_a),
        .i_op_b   (r_op_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_branch (w_alu_branch)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin grant in IDLE and next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible == 2'b11) begin
                    w_grant = r_prio ? 2'b10 : 2'b01;
                end else if (w_eligible[0]) begin
                    w_grant = 2'b01;
                end else if (w_eligible[1]) begin
                    w_grant = 2'b10;
                end else begin
                    w_grant = 2'b00;
                end
                if (w_grant != 2'b00) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload of the winning requester.
    always_comb begin
        w_sel_ctrl = req_ctrl[5:0];
        w_sel_a    = req_op_a[DATA_WIDTH-1:0];
        w_sel_b    = req_op_b[DATA_WIDTH-1:0];
        if (w_grant[1]) begin
            w_sel_ctrl = req_ctrl[11:6];
            w_sel_a    = req_op_a[2*DATA_WIDTH-1:DATA_WIDTH];
            w_sel_b    = req_op_b[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            w_sel_ctrl = req_ctrl[5:0];
            w_sel_a    = req_op_a[DATA_WIDTH-1:0];
            w_sel_b    = req_op_b[DATA_WIDTH-1:0];
        end
    end

    // Latch the accepted op and rotate priority away from the winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_ctrl  <= 6'b000000;
            r_op_a  <= {DATA_WIDTH{1'b0}};
            r_op_b  <= {DATA_WIDTH{1'b0}};
        end else if ((r_state == ST_IDLE) && (w_grant != 2'b00)) begin
            r_prio  <= ~w_grant[1];
            r_owner <= w_grant[1];
            r_ctrl  <= w_sel_ctrl;
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
        end else begin
            r_prio  <= r_prio;
            r_owner <= r_owner;
            r_ctrl  <= r_ctrl;
            r_op_a  <= r_op_a;
            r_op_b  <= r_op_b;
        end
    end

    // Response valid flags: pop on handshake, set when EXEC writes the owner's slot.
    // The owner's slot is empty during its EXEC, so set and pop never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end else begin
                    r_rsp_valid[i] <= r_rsp_valid[i];
                end
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid[r_owner] <= 1'b1;
            end else begin
                r_rsp_valid[r_owner] <= r_rsp_valid[r_owner] & ~rsp_ready[r_owner];
            end
        end
    end

    // Response payload registers: written only at the end of EXEC, otherwise held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_result <= {(2*DATA_WIDTH){1'b0}};
            r_rsp_zero   <= 2'b00;
            r_rsp_branch <= 2'b00;
        end else if (r_state == ST_EXEC) begin
            if (r_owner) begin
                r_rsp_result[2*DATA_WIDTH-1:DATA_WIDTH] <= w_alu_result;
            end else begin
                r_rsp_result[DATA_WIDTH-1:0] <= w_alu_result;
            end
            r_rsp_zero[r_owner]   <= w_alu_zero;
            r_rsp_branch[r_owner] <= w_alu_branch;
        end else begin
            r_rsp_result <= r_rsp_result;
            r_rsp_zero   <= r_rsp_zero;
            r_rsp_branch <= r_rsp_branch;
        end
    end

    assign req_ready  = w_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_branch = r_rsp_branch;
    assign busy       = (r_state == ST_EXEC);
endmodule
